// File: rtl/ipid_pkg.sv
// Shared widths, chunk index type and receiver state encoding for the IPID
// chunk stream; imported by both the streamer and the reassembler.
package ipid_pkg;

  localparam int DATA_W     = 256;
  localparam int CHUNK_W    = 16;
  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int IDX_W      = $clog2(NUM_CHUNKS);

  typedef logic [IDX_W-1:0] chunk_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/ipid_gap_timer.sv
// Counts consecutive idle cycles inside a frame; o_expired flags the
// increment that brings the count to GAP_MAX.
module ipid_gap_timer #(
  parameter int GAP_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CNT_W = $clog2(GAP_MAX + 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Combinational so the timeout lands on the GAP_MAX-th idle edge itself.
  assign o_expired = i_inc && (r_count == CNT_W'(GAP_MAX - 1));

endmodule

// File: rtl/ipid_reassemble.sv
// Rebuilds the 256-bit IPID from its 16-bit chunk stream, compares it with
// a golden value at completion and flags stalled frames with a sticky timeout.
module ipid_reassemble
  import ipid_pkg::*;
#(
  parameter int GAP_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [CHUNK_W-1:0] ipid_chunk,
  input  logic [DATA_W-1:0] golden_ipid,
  input  logic              clear,
  output logic [DATA_W-1:0] ipid_out,
  output logic              ipid_ready,
  output logic              match,
  output logic              timeout,
  output logic [7:0]        frame_count
);

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_ipid_out;
  chunk_idx_t        r_idx;
  logic              r_ready;
  logic              r_match;
  logic              r_timeout;
  logic [7:0]        r_frame_count;

  logic [DATA_W-1:0] w_shifted;
  logic              w_last;
  logic              w_gap_inc;
  logic              w_gap_expired;

  assign w_shifted = {r_shift[DATA_W-CHUNK_W-1:0], ipid_chunk};
  assign w_last    = (r_idx == chunk_idx_t'(NUM_CHUNKS - 1));
  assign w_gap_inc = (r_state == ST_COLLECT) && !valid && !clear;

  // Any cycle that is not an in-frame idle restarts the gap count.
  ipid_gap_timer #(.GAP_MAX(GAP_MAX)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_gap_inc),
    .i_inc    (w_gap_inc),
    .o_expired(w_gap_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred for the next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (valid) w_next_state = ST_COLLECT;
      ST_COLLECT: begin
        if (valid && w_last)              w_next_state = ST_DONE;
        else if (!valid && w_gap_expired) w_next_state = ST_ERR;
      end
      ST_DONE:    if (valid) w_next_state = ST_COLLECT;
      ST_ERR:     w_next_state = ST_ERR;
      default:    w_next_state = ST_IDLE;
    endcase
    if (clear) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift       <= '0;
      r_ipid_out    <= '0;
      r_idx         <= '0;
      r_ready       <= 1'b0;
      r_match       <= 1'b0;
      r_timeout     <= 1'b0;
      r_frame_count <= '0;
    end else if (clear) begin
      r_idx     <= '0;
      r_ready   <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (valid) begin
            r_shift <= w_shifted;
            r_idx   <= chunk_idx_t'(1);
            r_ready <= 1'b0;
            r_match <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (valid) begin
            r_shift <= w_shifted;
            r_idx   <= r_idx + chunk_idx_t'(1);
            if (w_last) begin
              r_ipid_out <= w_shifted;
              r_ready    <= 1'b1;
              r_match    <= (w_shifted == golden_ipid);
              if (r_frame_count != 8'hFF) r_frame_count <= r_frame_count + 8'd1;
            end
          end else if (w_gap_expired) begin
            r_timeout <= 1'b1;
            r_idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ipid_out    = r_ipid_out;
  assign ipid_ready  = r_ready;
  assign match       = r_match;
  assign timeout     = r_timeout;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ipid_reassemble.sv
// Directed self-checking bench for ipid_reassemble: nominal, mismatch, gap
// timeout, back-to-back, reset/clear corners and frame counter saturation.
module tb_ipid_reassemble;
  import ipid_pkg::*;

  localparam logic [DATA_W-1:0] V1 =
    256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a;
  localparam logic [DATA_W-1:0] V2 =
    256'h0123456789abcdeffedcba9876543210deadbeefcafef00d5555aaaa0f0ff0f0;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               valid = 1'b0;
  logic [CHUNK_W-1:0] ipid_chunk = '0;
  logic [DATA_W-1:0]  golden_ipid = '0;
  logic               clear = 1'b0;
  logic [DATA_W-1:0]  ipid_out;
  logic               ipid_ready;
  logic               match;
  logic               timeout;
  logic [7:0]         frame_count;

  int n_cmp  = 0;
  int n_fail = 0;

  ipid_reassemble #(.GAP_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .ipid_chunk (ipid_chunk),
    .golden_ipid(golden_ipid),
    .clear      (clear),
    .ipid_out   (ipid_out),
    .ipid_ready (ipid_ready),
    .match      (match),
    .timeout    (timeout),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [CHUNK_W-1:0] c);
    valid      = 1'b1;
    ipid_chunk = c;
    tick();
    valid      = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  // Sends chunks first..last (inclusive) of value v, MSB chunk first.
  task automatic send_range(input logic [DATA_W-1:0] v, input int first, input int last);
    logic [DATA_W-1:0] tmp;
    tmp = v;
    for (int i = first; i <= last; i++)
      send_chunk(tmp[DATA_W-1-CHUNK_W*i -: CHUNK_W]);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] v);
    send_range(v, 0, NUM_CHUNKS - 1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out",   ipid_out, '0);
    check("rst_ready", ipid_ready, '0);
    check("rst_match", match, '0);
    check("rst_tmo",   timeout, '0);
    check("rst_cnt",   frame_count, '0);
    rst = 1'b1;
    tick();

    // Nominal frame with one-cycle completion latency
    golden_ipid = V1;
    send_range(V1, 0, 14);
    check("nom_ready_15", ipid_ready, 1'b0);
    send_range(V1, 15, 15);
    check("nom_ready", ipid_ready, 1'b1);
    check("nom_out",   ipid_out, V1);
    check("nom_match", match, 1'b1);
    check("nom_cnt",   frame_count, 8'd1);
    idle(12);
    check("done_hold_ready", ipid_ready, 1'b1);
    check("done_no_tmo",     timeout, 1'b0);

    // Mismatch: golden bit 0 flipped
    golden_ipid = V1 ^ 256'd1;
    send_range(V1, 0, 0);
    check("mm_ready_drop", ipid_ready, 1'b0);
    send_range(V1, 1, 15);
    check("mm_ready", ipid_ready, 1'b1);
    check("mm_match", match, 1'b0);
    check("mm_out",   ipid_out, V1);
    check("mm_cnt",   frame_count, 8'd2);
    golden_ipid = V1;

    // Seven idle cycles after chunk 5 are tolerated
    send_range(V1, 0, 5);
    idle(7);
    check("gap7_tmo", timeout, 1'b0);
    send_range(V1, 6, 15);
    check("gap7_ready", ipid_ready, 1'b1);
    check("gap7_match", match, 1'b1);
    check("gap7_cnt",   frame_count, 8'd3);

    // Eight idle cycles time out; later chunks ignored until clear
    send_range(V1, 0, 5);
    idle(7);
    check("gap8_tmo_7", timeout, 1'b0);
    idle(1);
    check("gap8_tmo_8", timeout, 1'b1);
    send_frame(V1);
    idle(10);
    check("err_ready", ipid_ready, 1'b0);
    check("err_tmo",   timeout, 1'b1);
    check("err_cnt",   frame_count, 8'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_tmo", timeout, 1'b0);
    check("clr_out", ipid_out, V1);
    check("clr_cnt", frame_count, 8'd3);
    golden_ipid = V2;
    send_frame(V2);
    check("postclr_ready", ipid_ready, 1'b1);
    check("postclr_out",   ipid_out, V2);
    check("postclr_match", match, 1'b1);
    check("postclr_cnt",   frame_count, 8'd4);

    // Back-to-back frames with valid held high; golden switches mid-run
    golden_ipid = V1;
    send_range(V1, 0, 15);
    check("b2b_ready_16", ipid_ready, 1'b1);
    check("b2b_out_16",   ipid_out, V1);
    check("b2b_match_16", match, 1'b1);
    golden_ipid = V2;
    send_range(V2, 0, 0);
    check("b2b_ready_17", ipid_ready, 1'b0);
    send_range(V2, 1, 15);
    check("b2b_ready_32", ipid_ready, 1'b1);
    check("b2b_out_32",   ipid_out, V2);
    check("b2b_match_32", match, 1'b1);
    check("b2b_cnt",      frame_count, 8'd6);

    // Producer pause of one cycle mid-frame
    golden_ipid = V1;
    send_range(V1, 0, 7);
    idle(1);
    send_range(V1, 8, 15);
    check("pause_out",   ipid_out, V1);
    check("pause_match", match, 1'b1);
    check("pause_cnt",   frame_count, 8'd7);

    // Reset after chunk 9 discards everything
    send_range(V2, 0, 8);
    rst = 1'b0;
    #2;
    check("mrst_out",   ipid_out, '0);
    check("mrst_ready", ipid_ready, 1'b0);
    check("mrst_match", match, 1'b0);
    check("mrst_cnt",   frame_count, 8'd0);
    rst = 1'b1;
    tick();
    send_frame(V1);
    check("mrst_f_out",   ipid_out, V1);
    check("mrst_f_match", match, 1'b1);
    check("mrst_f_cnt",   frame_count, 8'd1);

    // Clear with valid in the same cycle drops the chunk
    clear      = 1'b1;
    valid      = 1'b1;
    ipid_chunk = 16'hbeef;
    tick();
    clear = 1'b0;
    valid = 1'b0;
    check("cv_ready", ipid_ready, 1'b0);
    check("cv_out",   ipid_out, V1);
    golden_ipid = V2;
    send_range(V2, 0, 14);
    check("cv_ready_15", ipid_ready, 1'b0);
    send_range(V2, 15, 15);
    check("cv_ready_16", ipid_ready, 1'b1);
    check("cv_out_16",   ipid_out, V2);
    check("cv_cnt",      frame_count, 8'd2);

    // Frame counter saturation
    repeat (252) send_frame(V2);
    check("sat_fe", frame_count, 8'hFE);
    repeat (4) send_frame(V2);
    check("sat_ff", frame_count, 8'hFF);
    check("sat_match", match, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
